// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: cursor owner and character-RAM writer for the 80x30 text display.
// Debounces three keys (right, down, write), holds the last received ASCII byte, moves
// the cursor, issues handshaked RAM writes and produces the blink phase for the underline.
// Build option: define AUTO_WRITE_EN for terminal mode, where every received byte is also
// written at the cursor and a byte arriving before the previous one is taken sets overrun.
module text_cursor_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int DB_CYCLES    = 250000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  key,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_req,
  output logic [11:0] wr_addr,
  output logic [6:0]  wr_data,
  input  logic        wr_ack,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        cursor_on,
  output logic        overrun
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int BLW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, ADVANCE} state_t;

  state_t           state;
  logic [2:0]       key_meta, key_sync, key_level, key_ev;
  logic [DBW-1:0]   db_cnt [3];
  logic [6:0]       char_reg;
  logic             ev_right, ev_down, ev_write, ev_write_set;
  logic             take_write, take_right, take_down, do_ack, cursor_move;
  logic             x_last, y_last;
  logic [6:0]       x_inc;
  logic [4:0]       y_inc;
  logic [11:0]      lin_addr;
  logic [BLW-1:0]   blink_cnt;
  logic             unused_rx_msb;

  assign unused_rx_msb = rx_data[7];

  // Bring the raw buttons into the clock domain.
  // NOTE: keys are asynchronous; the first flop may go metastable, so nothing but the second flop reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Debounce: a level differing from the accepted one must hold DB_CYCLES samples; any bounce restarts the count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level <= '0;
      key_ev    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        key_ev[i] <= 1'b0;
        if (key_sync[i] == key_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          db_cnt[i]    <= '0;
          key_level[i] <= key_sync[i];
          key_ev[i]    <= key_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_WRITE_EN
  assign ev_write_set = key_ev[2] | rx_valid;
`else
  assign ev_write_set = key_ev[2];
`endif

  // Cursor arithmetic and RAM address of the current cell.
  assign x_last   = (cur_x == 7'(COLS - 1));
  assign y_last   = (cur_y == 5'(ROWS - 1));
  assign x_inc    = x_last ? 7'd0 : cur_x + 7'd1;
  assign y_inc    = y_last ? 5'd0 : cur_y + 5'd1;
  assign lin_addr = 12'(cur_y) * 12'(COLS) + 12'(cur_x);

  // Decide which pending request IDLE consumes this cycle (write > right > down).
  // NOTE: every output gets a default first so no latch is inferred on untaken paths.
  always_comb begin
    take_write = 1'b0;
    take_right = 1'b0;
    take_down  = 1'b0;
    if (state == IDLE) begin
      if (ev_write)      take_write = 1'b1;
      else if (ev_right) take_right = 1'b1;
      else if (ev_down)  take_down  = 1'b1;
    end
    do_ack      = (state == WRITE) && wr_ack;
    cursor_move = take_right | take_down | do_ack;
  end

  // Byte register and one-deep event latches; a consumed latch clears unless a new event lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_reg <= 7'h20;
      ev_right <= 1'b0;
      ev_down  <= 1'b0;
      ev_write <= 1'b0;
    end else begin
      if (rx_valid) char_reg <= rx_data[6:0];
      ev_right <= (ev_right & ~take_right) | key_ev[0];
      ev_down  <= (ev_down  & ~take_down)  | key_ev[1];
      ev_write <= (ev_write & ~take_write) | ev_write_set;
    end
  end

`ifdef AUTO_WRITE_EN
  // Sticky overrun: a byte replaced the one still waiting to be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  overrun <= 1'b0;
    else if (rx_valid && ev_write && !take_write) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  // Main FSM: cursor moves in IDLE, write handshake in WRITE; the advance is registered on ack so ADVANCE shows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 7'h20;
      cur_x   <= '0;
      cur_y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_write) begin
            wr_data <= char_reg;
            wr_addr <= lin_addr;
            wr_req  <= 1'b1;
            state   <= WRITE;
          end else if (take_right) begin
            cur_x <= x_inc;
          end else if (take_down) begin
            cur_y <= y_inc;
          end
        end
        WRITE: begin
          if (do_ack) begin
            wr_req <= 1'b0;
            cur_x  <= x_inc;
            if (x_last) cur_y <= y_inc;
            state  <= ADVANCE;
          end
        end
        ADVANCE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Blink phase: toggles every BLINK_CYCLES, restarts visible whenever the cursor moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      cursor_on <= 1'b1;
    end else if (cursor_move) begin
      blink_cnt <= '0;
      cursor_on <= 1'b1;
    end else if (blink_cnt == BLW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      cursor_on <= ~cursor_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Testbench for text_cursor_ctrl: random key/byte traffic against a cell-level cursor model,
// with a write scoreboard checked by an independent monitor on the RAM port.
module tb_text_cursor_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  key;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        wr_ack;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        cursor_on;
  logic        overrun;

  text_cursor_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DB_CYCLES(4), .BLINK_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .cur_x(cur_x), .cur_y(cur_y), .cursor_on(cursor_on), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Expected RAM writes: address, data, and cycles wr_req stays high (-1 when not checked).
  typedef struct {int addr; int data; int len;} wr_t;
  wr_t exp_q[$];

  // Reference model: cursor as (column,row), current character.
  int mx, my, mch;

  // RAM ack model: ack once wr_req has been high for ack_delay earlier cycles, unless held off.
  int   ack_delay = 0;
  logic ack_hold  = 1'b0;
  int   req_cnt   = 0;
  always @(posedge clk) req_cnt <= wr_req ? req_cnt + 1 : 0;
  assign wr_ack = wr_req && !ack_hold && (req_cnt >= ack_delay);

  // Monitor: pops an expected write on each wr_req rise and checks payload, stability and length.
  logic prev_req = 1'b0;
  int   hi_len   = 0;
  wr_t  cur_wr   = '{-1, -1, -1};
  always @(negedge clk) begin
    if (wr_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
        cur_wr = '{-1, -1, -1};
      end else begin
        cur_wr = exp_q.pop_front();
        check("wr_addr", wr_addr, cur_wr.addr);
        check("wr_data", wr_data, cur_wr.data);
      end
      hi_len = 1;
    end else if (wr_req) begin
      hi_len++;
      if (cur_wr.addr >= 0) check("wr_addr_hold", wr_addr, cur_wr.addr);
    end
    if (!wr_req && prev_req && rst_n && cur_wr.len > 0) check("wr_req_len", hi_len, cur_wr.len);
    prev_req = wr_req;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int glitches);
    repeat (glitches) begin
      key = mask; tick(3);
      key = 3'b000; tick(3);
    end
    key = mask; tick(10);
    key = 3'b000; tick(10);
  endtask

  task automatic check_pos();
    check("cur_x", cur_x, mx);
    check("cur_y", cur_y, my);
  endtask

  task automatic model_write(input int len);
    int lin;
    exp_q.push_back('{my * COLS + mx, mch, len});
    lin = (my * COLS + mx + 1) % CELLS;
    mx  = lin % COLS;
    my  = lin / COLS;
  endtask

  task automatic do_right();
    press(3'b001, 0);
    mx = (mx + 1) % COLS;
    check_pos();
  endtask

  task automatic do_down();
    press(3'b010, 0);
    my = (my + 1) % ROWS;
    check_pos();
  endtask

  task automatic key_write();
    model_write(ack_delay + 1);
    press(3'b100, 0);
    check_pos();
  endtask

  task automatic send_byte_raw(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mch = int'(b[6:0]);
`ifdef AUTO_WRITE_EN
    model_write(ack_delay + 1);
`endif
    send_byte_raw(b);
    tick(12);
  endtask

  task automatic wait_req_high(input int budget);
    int k = 0;
    while (!wr_req && k < budget) begin tick(1); k++; end
    check("wr_req_rise_in_budget", wr_req, 1);
  endtask

  initial begin
    rst_n = 1'b0; key = 3'b000; rx_data = 8'h00; rx_valid = 1'b0;
    mx = 0; my = 0; mch = 'h20;
    tick(3);
    // Reset values
    check("rst_cur_x", cur_x, 0);
    check("rst_cur_y", cur_y, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 'h20);
    check("rst_cursor_on", cursor_on, 1);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    // Idle blink: visible for the first 16 cycles, then toggles every 16
    for (int e = 1; e <= 40; e++) begin
      tick(1);
      check("blink_idle", cursor_on, ((e / 16) % 2) == 0);
    end
    check_pos();
    check("idle_wr_req", wr_req, 0);

    // Glitchy right key: exactly one move; then wrap the row back to column 0
    press(3'b001, 2);
    mx = 1;
    check_pos();
    for (int i = 1; i < COLS; i++) do_right();

    // Byte (bit 7 ignored) then write key; ack two cycles after wr_req
    ack_delay = 2;
    send_byte(8'hC1);
    key_write();

    // Bottom-right corner write with immediate ack wraps to (0,0)
    send_byte(8'h5A);
    ack_delay = 0;
    while (mx != COLS - 1) do_right();
    while (my != ROWS - 1) do_down();
    key_write();

    // Moves requested while a write waits for ack are applied afterwards, in order
    ack_hold = 1'b1;
    model_write(-1);
    press(3'b100, 0);
    wait_req_high(40);
    press(3'b011, 0);
    mx = (mx + 1) % COLS;
    my = (my + 1) % ROWS;
    ack_hold = 1'b0;
    tick(10);
    check_pos();
    check("cursor_on_after_move", cursor_on, 1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: do_right();
        1: do_down();
        2: send_byte(8'($urandom_range(0, 255)));
        default: begin
          ack_delay = $urandom_range(0, 3);
          key_write();
        end
      endcase
    end

`ifdef AUTO_WRITE_EN
    // Terminal mode: second byte lost while the first write is stalled
    ack_hold = 1'b1; ack_delay = 1;
    mch = 'h61; model_write(-1);
    send_byte_raw(8'h61); tick(4);
    send_byte_raw(8'h62); tick(3);
    check("overrun_after_2nd", overrun, 0);
    mch = 'h63; model_write(2);
    send_byte_raw(8'h63); tick(3);
    check("overrun_after_3rd", overrun, 1);
    ack_hold = 1'b0;
    tick(15);
    check_pos();
    check("overrun_sticky", overrun, 1);
`else
    // Back-to-back bytes only update the character; the latest one is written by the key
    send_byte_raw(8'h61);
    send_byte_raw(8'h62);
    tick(5);
    check("overrun_off", overrun, 0);
    mch = 'h62;
    ack_delay = 1;
    key_write();
`endif

    // Reset during a stalled write abandons it
    ack_hold = 1'b1;
    model_write(-1);
    press(3'b100, 0);
    wait_req_high(40);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_wr_req", wr_req, 0);
    tick(2);
    rst_n = 1'b1;
    ack_hold = 1'b0;
    mx = 0; my = 0; mch = 'h20;
    tick(5);
    check_pos();
    check("rst_mid_wr_data", wr_data, 'h20);
    check("rst_mid_overrun", overrun, 0);
    check("writes_all_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/text_cursor_ctrl.md
# text_cursor_ctrl

Sequencing controller for the 80x30 text-mode display. It debounces the three user keys and accepts ASCII bytes from the UART receiver. It owns the cursor position and issues handshaked write requests into the character RAM read by the screen generator. The cursor position and blink outputs drive the underline overlay in the pixel path; the block runs in the 25 MHz pixel clock domain.

## Interface
- COLS, 80: characters per row.
- ROWS, 30: character rows.
- DB_CYCLES, 250000: stable cycles a key must hold before its level is accepted (10 ms at 25 MHz).
- BLINK_CYCLES, 12500000: cycles per cursor blink half-period (0.5 s).

- clk  in  1  pixel clock (25 MHz), all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  3  raw push-buttons, active-high, asynchronous; key[0] right, key[1] down, key[2] write.
- rx_data  in  8  received byte; only bits [6:0] are used.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- wr_req  out  1  character RAM write request.
- wr_addr  out  12  cur_y*COLS + cur_x.
- wr_data  out  7  ASCII code to write.
- wr_ack  in  1  RAM accepted write; may be high in the same cycle wr_req rises, or later.
- cur_x  out  7  cursor column, 0..COLS-1.
- cur_y  out  5  cursor row, 0..ROWS-1.
- cursor_on  out  1  blink phase; underline drawn when 1.
- overrun  out  1  sticky: byte lost; cleared only by reset.

## Operation
- Key path, per key:
  - Two-flop synchronizer.
  - Debounce counter: restarts on any change of the synchronized level; the level is accepted after DB_CYCLES equal samples.
  - Accepted 0->1 transition gives a one-cycle event.
- Byte path: rx_valid loads char_reg <= rx_data[6:0]. char_reg resets to 7'h20 (space).
- Event latches: ev_right, ev_down, ev_write; one-deep.
  - Set by their event.
  - Cleared when the FSM consumes them.
  - A repeat event while a latch is still set is absorbed.
- FSM states: IDLE, WRITE, ADVANCE.
- IDLE priority is write > right > down; only one request is consumed per visit.
  - Write: latch wr_data <= char_reg and wr_addr <= current address, then go to WRITE.
  - Right: cur_x+1, wrapping COLS-1 -> 0; cur_y unchanged. Stay in IDLE.
  - Down: cur_y+1, wrapping ROWS-1 -> 0; cur_x unchanged. Stay in IDLE.
- WRITE: wr_req=1; wr_addr and wr_data held stable. When wr_ack is sampled 1, go to ADVANCE.
- ADVANCE: wr_req=0 and the cursor advances.
  - cur_x+1.
  - At cur_x=COLS-1: cur_x=0, cur_y+1; at cur_y=ROWS-1, cur_y wraps to 0.
  - Then return to IDLE.
- Events arriving in WRITE or ADVANCE are latched and serviced in later IDLE visits.
- Blink:
  - Counter toggles cursor_on after BLINK_CYCLES.
  - Any cursor change reloads the counter and forces cursor_on=1.
- Width rule: wr_addr uses a 12-bit multiply-add; the maximum is 2399.
- Reset values: cur_x=0, cur_y=0, wr_req=0, wr_addr=0, wr_data=7'h20, cursor_on=1, overrun=0, state IDLE, all latches clear.
- Reset mid-write: wr_req drops asynchronously and the write is abandoned.

## Timing
- Key-press latency: raw edge to event is 2 sync cycles + DB_CYCLES + 1.
- Move: event at cycle N -> latch N+1 -> cur_x or cur_y updated at N+2, when the FSM is in IDLE.
- Write: ev_write consumed at N -> wr_req=1 at N+1.
  - ack sampled at cycle M -> wr_req=0 and cursor advanced at M+1 -> IDLE at M+2.
  - Minimum write cost is 3 cycles.
- rx_valid in the same cycle as IDLE consumes a write: the old char_reg is written and the new byte is kept.

## Configuration
- AUTO_WRITE_EN defined (terminal mode):
  - Each rx_valid also sets ev_write, so received bytes are written at the cursor and the cursor advances.
  - If rx_valid arrives while ev_write is still set, the earlier byte is replaced and overrun is set to 1.
  - key[2] still sets ev_write and rewrites char_reg.
- Undefined: bytes only update char_reg; writes occur only on key[2]; overrun stays 0.

## Test plan
Bench parameters: DB_CYCLES=4, BLINK_CYCLES=16.

- Reset, then idle 40 cycles -> cur_x=0, cur_y=0, wr_req=0, wr_data=7'h20, cursor_on toggles every 16 cycles.
- key[0] with 3-cycle glitches, then held 10 cycles -> exactly one move, cur_x=1. Repeat 80 presses -> cur_x wraps to 0, cur_y=0.
- Byte 0x41, then key[2]; RAM model acks 2 cycles after wr_req -> one write with addr 0 and data 0x41; then cur_x=1; wr_req high exactly 3 cycles.
- Cursor at (79,29) and a write with immediate ack -> wr_addr=2399; then cur_x=0, cur_y=0.
- key[0] and key[1] pressed while a write awaits ack -> after the write, cursor ends at (2,1) from (0,0); both moves applied in order.
- AUTO_WRITE_EN, ack withheld, three bytes 0x61 0x62 0x63 -> write 0x61; 0x62 is lost, overrun=1; 0x63 is written next.
